// File: rtl/mem_stage.sv
// MEM pipeline stage. Registers the EX->MEM bus and performs load byte/halfword
// extraction and writeback selection. A hold buffer keeps the SRAM read data
// while MEM is stalled.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 84,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic                    fresh;
    logic                    hold_valid;
    logic [31:0]             hold_data;

    logic [1:0]  offset;
    logic        is_lb, is_lbu, is_lh, is_lhu;
    logic [31:0] pc;
    logic        data_ram_en;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] rdata_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    assign offset      = bus_r[81:80];
    assign is_lb       = bus_r[79];
    assign is_lbu      = bus_r[78];
    assign is_lh       = bus_r[77];
    assign is_lhu      = bus_r[76];
    assign pc          = bus_r[75:44];
    assign data_ram_en = bus_r[43];
    assign sel_rf_res  = bus_r[38];
    assign rf_we       = bus_r[37];
    assign rf_waddr    = bus_r[36:32];
    assign ex_result   = bus_r[31:0];

    // Offset copy and write-enables are not needed past EX.
    assign unused_bits = ^{bus_r[83:82], bus_r[42:39], stall[5], stall[2:0]};

    // Pipeline register: bubble when EX->MEM stops but MEM->WB flows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_r <= '0;
        end else if (stall[3] && !stall[4]) begin
            bus_r <= '0;
        end else if (!stall[3]) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    // Fresh marks the one cycle in which SRAM read data belongs to bus_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fresh <= 1'b0;
        end else begin
            fresh <= !stall[3];
        end
    end

    // Hold buffer: capture load data on the fresh cycle if MEM stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (fresh && stall[4] && data_ram_en && sel_rf_res) begin
            hold_valid <= 1'b1;
            hold_data  <= data_sram_rdata;
        end else if (!stall[3]) begin
            hold_valid <= 1'b0;
        end
    end

    assign rdata_eff = hold_valid ? hold_data : data_sram_rdata;

    // Load extraction and extension; flag priority lb > lbu > lh > lhu.
    always_comb begin
        byte_sel = rdata_eff[7:0];
        case (offset)
            2'd0:    byte_sel = rdata_eff[7:0];
            2'd1:    byte_sel = rdata_eff[15:8];
            2'd2:    byte_sel = rdata_eff[23:16];
            default: byte_sel = rdata_eff[31:24];
        endcase
        half_sel  = offset[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        load_data = rdata_eff;
        if (is_lb) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (is_lbu) begin
            load_data = {24'h0, byte_sel};
        end else if (is_lh) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (is_lhu) begin
            load_data = {16'h0, half_sel};
        end
    end

    assign rf_wdata      = sel_rf_res ? load_data : ex_result;
    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-instruction vectors
// followed by hand-written hold, bubble and reset sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [83:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;

    int n_vec;
    int n_bad;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [83:0] bus;
        logic [31:0] rdata;
        logic [69:0] exp;
    } vec_t;

    vec_t vecs[12];

    // flags = {lb, lbu, lh, lhu}
    function automatic logic [83:0] mk(input logic [1:0] off, input logic [3:0] flags,
                                       input logic [31:0] pc, input logic en,
                                       input logic [3:0] wen, input logic sel,
                                       input logic we, input logic [4:0] wa,
                                       input logic [31:0] res);
        return {off, off, flags, pc, en, wen, sel, we, wa, res};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [69:0] exp);
        check({name, " wb"}, mem_to_wb_bus, exp);
        check({name, " id"}, {32'h0, mem_to_id_bus}, {32'h0, exp[37:0]});
    endtask

    localparam logic [31:0] RD = 32'h1234_80F7;

    initial begin
        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{mk(2'd0, 4'b0000, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h0),
                     32'h8000_00F0, {32'h100, 1'b1, 5'd5, 32'h8000_00F0}};
        vecs[1]  = '{mk(2'd0, 4'b1000, 32'h104, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0),
                     RD, {32'h104, 1'b1, 5'd6, 32'hFFFF_FFF7}};
        vecs[2]  = '{mk(2'd1, 4'b0100, 32'h108, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0),
                     RD, {32'h108, 1'b1, 5'd6, 32'h0000_0080}};
        vecs[3]  = '{mk(2'd2, 4'b0010, 32'h10C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0),
                     RD, {32'h10C, 1'b1, 5'd6, 32'h0000_1234}};
        vecs[4]  = '{mk(2'd0, 4'b0001, 32'h110, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0),
                     RD, {32'h110, 1'b1, 5'd6, 32'h0000_80F7}};
        vecs[5]  = '{mk(2'd0, 4'b0010, 32'h114, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h0),
                     RD, {32'h114, 1'b1, 5'd6, 32'hFFFF_80F7}};
        vecs[6]  = '{mk(2'd3, 4'b1000, 32'h118, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0),
                     RD, {32'h118, 1'b1, 5'd8, 32'h0000_0012}};
        vecs[7]  = '{mk(2'd2, 4'b0100, 32'h11C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0),
                     RD, {32'h11C, 1'b1, 5'd8, 32'h0000_0034}};
        vecs[8]  = '{mk(2'd0, 4'b0000, 32'h120, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h42),
                     32'hDEAD_BEEF, {32'h120, 1'b1, 5'd7, 32'h0000_0042}};
        vecs[9]  = '{mk(2'd0, 4'b0000, 32'h124, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h2000),
                     RD, {32'h124, 1'b0, 5'd0, 32'h0000_2000}};
        vecs[10] = '{mk(2'd1, 4'b1001, 32'h128, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0),
                     RD, {32'h128, 1'b1, 5'd9, 32'hFFFF_FF80}};
        vecs[11] = '{mk(2'd3, 4'b0010, 32'h12C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0),
                     RD, {32'h12C, 1'b1, 5'd10, 32'h0000_1234}};

        // Reset state
        rst             = 1'b1;
        stall           = 6'b0;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'hFFFF_FFFF;
        #2;
        check_both("reset", 70'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: each vector enters MEM, read data arrives in the fresh cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            stall           = 6'b0;
            ex_to_mem_bus   = vecs[i].bus;
            data_sram_rdata = 32'h5A5A_5A5A;
            @(posedge clk);
            #1 data_sram_rdata = vecs[i].rdata;
            #1 check_both($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hold buffer across a 3-cycle MEM stall
        @(negedge clk);
        stall         = 6'b0;
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0);
        @(posedge clk);
        #1 data_sram_rdata = 32'hCAFE_BABE;
        stall         = 6'b011111;
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h204, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h77);
        #1 check_both("hold fresh", {32'h200, 1'b1, 5'd9, 32'hCAFE_BABE});
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 data_sram_rdata = 32'hDEAD_BEEF;
            #1 check_both($sformatf("hold stall%0d", k), {32'h200, 1'b1, 5'd9, 32'hCAFE_BABE});
        end
        @(negedge clk);
        stall = 6'b0;
        #1 check_both("hold release", {32'h200, 1'b1, 5'd9, 32'hCAFE_BABE});
        @(posedge clk);
        #1 check_both("next after hold", {32'h204, 1'b1, 5'd3, 32'h0000_0077});
        // A later load must see live read data, not the old hold value
        @(negedge clk);
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h208, 1'b1, 4'h0, 1'b1, 1'b1, 5'd4, 32'h0);
        @(posedge clk);
        #1 data_sram_rdata = 32'h1111_2222;
        #1 check_both("hold cleared", {32'h208, 1'b1, 5'd4, 32'h1111_2222});

        // Bubble: stall[3]=1, stall[4]=0
        @(negedge clk);
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'hABCD);
        @(posedge clk);
        #1 check_both("pre-bubble", {32'h300, 1'b1, 5'd11, 32'h0000_ABCD});
        @(negedge clk);
        stall = 6'b001111;
        @(posedge clk);
        #1 check_both("bubble", 70'h0);

        // Full stall keeps outputs unchanged
        @(negedge clk);
        stall         = 6'b0;
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h99);
        @(posedge clk);
        @(negedge clk);
        stall         = 6'b011111;
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h308, 1'b0, 4'h0, 1'b0, 1'b1, 5'd13, 32'h55);
        @(posedge clk);
        #1 check_both("full stall", {32'h304, 1'b1, 5'd12, 32'h0000_0099});

        // Asynchronous reset while a load is held
        @(negedge clk);
        stall         = 6'b0;
        ex_to_mem_bus = mk(2'd0, 4'b0000, 32'h400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h0);
        @(posedge clk);
        #1 data_sram_rdata = 32'h0BAD_F00D;
        stall = 6'b011111;
        @(posedge clk);
        #1 data_sram_rdata = 32'h3333_4444;
        #1 check_both("held before rst", {32'h400, 1'b1, 5'd14, 32'h0BAD_F00D});
        #1 rst = 1'b1;
        #1 check_both("async rst", 70'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("hold_valid after rst", {69'h0, dut.hold_valid}, 70'h0);
        check_both("after rst", 70'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
